// File: rtl/charge_request_sequencer.sv
`timescale 1ns/1ps
// charge_request_sequencer: turns keypad entries into one validated charge request and reports the outcome.
// Latency: done/DOWNSTREAM error STROBE_CYCLES+RESP_WAIT+2 cycles after ENTER; validation error 2 cycles after ENTER.
// Backpressure: none; keys arriving while busy (VALIDATE..REPORT) are dropped, CANCEL included.
// Optional per-product stock shadow and OVERFLOW check: define CHARGE_STOCK_SHADOW_EN.
module charge_request_sequencer #(
  parameter int MAX_CODE      = 4,
  parameter int MAX_STOCK     = 15,
  parameter int STROBE_CYCLES = 4,
  parameter int RESP_WAIT     = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_value,
  input  logic       dp_in,
  output logic [2:0] productCode,
  output logic [3:0] productCount,
  output logic       charge_strobe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_COUNT,
    S_VALIDATE,
    S_ISSUE,
    S_WAIT,
    S_REPORT
  } state_t;

  localparam logic [2:0] E_NONE       = 3'd0;
  localparam logic [2:0] E_BAD_CODE   = 3'd1;
  localparam logic [2:0] E_BAD_COUNT  = 3'd2;
  localparam logic [2:0] E_DOWNSTREAM = 3'd4;

  localparam logic [3:0] LP_MAX_CODE    = 4'(MAX_CODE);
  localparam logic [7:0] LP_MAX_STOCK8  = 8'(MAX_STOCK);
  localparam logic [7:0] LP_STROBE_LAST = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] LP_WAIT_LAST   = 8'(RESP_WAIT - 1);

  state_t     r_state;
  logic [3:0] r_code;        // full digit kept so codes 5-9 remain detectable
  logic [7:0] r_cnt_acc;     // decimal count accumulator
  logic [1:0] r_digits;      // count digits seen, saturates at 3
  logic       r_bad_count;   // sticky: third digit or count above the stock ceiling
  logic [7:0] r_timer;
  logic [2:0] r_prod_code;
  logic [3:0] r_prod_count;
  logic       r_strobe;
  logic       r_busy;
  logic       r_done;
  logic       r_error;
  logic [2:0] r_err_code;

  logic       w_is_digit;
  logic       w_is_enter;
  logic       w_is_cancel;
  logic [7:0] w_cnt_next;
  logic       w_cnt_bad;
  logic       w_overflow;

  assign w_is_digit  = key_valid && (key_value <= 4'd9);
  assign w_is_enter  = key_valid && (key_value == 4'hA);
  assign w_is_cancel = key_valid && (key_value == 4'hB);
  assign w_cnt_next  = (r_cnt_acc * 8'd10) + {4'd0, key_value};
  assign w_cnt_bad   = (r_digits == 2'd2) || (w_cnt_next > LP_MAX_STOCK8);

`ifdef CHARGE_STOCK_SHADOW_EN
  localparam logic [2:0] E_OVERFLOW    = 3'd3;
  localparam logic [4:0] LP_MAX_STOCK5 = 5'(MAX_STOCK);

  logic [3:0] r_shadow [MAX_CODE+1];
  logic [3:0] w_shadow_cur;

  // Stock already charged for the product being validated; only meaningful once the code check passed.
  assign w_shadow_cur = r_shadow[r_code[2:0]];
  assign w_overflow   = ({1'b0, w_shadow_cur} + {1'b0, r_cnt_acc[3:0]}) > LP_MAX_STOCK5;
`else
  assign w_overflow   = 1'b0;
`endif

  // Request sequencer: key entry, validation, strobe, response wait and one-cycle report.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_code       <= '0;
      r_cnt_acc    <= '0;
      r_digits     <= '0;
      r_bad_count  <= 1'b0;
      r_timer      <= '0;
      r_prod_code  <= '0;
      r_prod_count <= '0;
      r_strobe     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_err_code   <= E_NONE;
`ifdef CHARGE_STOCK_SHADOW_EN
      for (int i = 0; i <= MAX_CODE; i++) begin
        r_shadow[i] <= '0;
      end
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_digit) begin
            r_code      <= key_value;
            r_cnt_acc   <= '0;
            r_digits    <= '0;
            r_bad_count <= 1'b0;
            r_state     <= S_GET_COUNT;
          end
        end

        S_GET_COUNT: begin
          if (w_is_digit) begin
            r_cnt_acc <= w_cnt_next;
            if (r_digits != 2'd3) begin
              r_digits <= r_digits + 2'd1;
            end
            if (w_cnt_bad) begin
              r_bad_count <= 1'b1;
            end
          end else if (w_is_cancel) begin
            r_code      <= '0;
            r_cnt_acc   <= '0;
            r_digits    <= '0;
            r_bad_count <= 1'b0;
            r_state     <= S_IDLE;
          end else if (w_is_enter) begin
            r_busy  <= 1'b1;
            r_state <= S_VALIDATE;
          end
        end

        S_VALIDATE: begin
          if (r_code > LP_MAX_CODE) begin
            r_error    <= 1'b1;
            r_err_code <= E_BAD_CODE;
            r_state    <= S_REPORT;
          end else if ((r_digits == 2'd0) || (r_cnt_acc == 8'd0) || r_bad_count) begin
            r_error    <= 1'b1;
            r_err_code <= E_BAD_COUNT;
            r_state    <= S_REPORT;
          end else if (w_overflow) begin
            r_error    <= 1'b1;
`ifdef CHARGE_STOCK_SHADOW_EN
            r_err_code <= E_OVERFLOW;
`else
            r_err_code <= E_BAD_COUNT;
`endif
            r_state    <= S_REPORT;
          end else begin
            r_prod_code  <= r_code[2:0];
            r_prod_count <= r_cnt_acc[3:0];
            r_strobe     <= 1'b1;
            r_timer      <= LP_STROBE_LAST;
            r_state      <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (r_timer == 8'd0) begin
            r_strobe <= 1'b0;
            r_timer  <= LP_WAIT_LAST;
            r_state  <= S_WAIT;
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end

        S_WAIT: begin
          if (r_timer == 8'd0) begin
            if (dp_in) begin
              r_error    <= 1'b1;
              r_err_code <= E_DOWNSTREAM;
            end else begin
              r_done     <= 1'b1;
              r_err_code <= E_NONE;
`ifdef CHARGE_STOCK_SHADOW_EN
              r_shadow[r_prod_code] <= r_shadow[r_prod_code] + r_prod_count;
`endif
            end
            r_state <= S_REPORT;
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end

        S_REPORT: begin
          r_done      <= 1'b0;
          r_error     <= 1'b0;
          r_busy      <= 1'b0;
          r_code      <= '0;
          r_cnt_acc   <= '0;
          r_digits    <= '0;
          r_bad_count <= 1'b0;
          r_state     <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign productCode   = r_prod_code;
  assign productCount  = r_prod_count;
  assign charge_strobe = r_strobe;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign err_code      = r_err_code;

endmodule

// File: tb/tb_charge_request_sequencer.sv
`timescale 1ns/1ps
// Bench for charge_request_sequencer: directed request table, hand sequences for cancel and
// mid-operation reset, then randomized requests checked against a key-list reference model.
module tb_charge_request_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_value;
  logic       dp_in;
  logic [2:0] productCode;
  logic [3:0] productCount;
  logic       charge_strobe;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] err_code;

  charge_request_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .key_valid     (key_valid),
    .key_value     (key_value),
    .dp_in         (dp_in),
    .productCode   (productCode),
    .productCount  (productCount),
    .charge_strobe (charge_strobe),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_code      (err_code)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef CHARGE_STOCK_SHADOW_EN
  int m_shadow [5];
`endif

  typedef struct packed {
    logic [3:0]  nkeys;
    logic [31:0] keys;     // first key in the highest used nibble
    logic        dp;
    logic [2:0]  exp_err;
    logic [2:0]  exp_code;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int all_outputs();
    return int'({productCode, productCount, charge_strobe, busy, done, error, err_code});
  endfunction

  // Reference model: interprets the whole key list by the keypad rules.
  function automatic void model(input logic [3:0] keys[$], input bit dp,
                                output int e_err, output int e_code, output int e_cnt);
    bit have_code = 0;
    int code = 0;
    int digs[$];
    int val = 0;
    int k;
    foreach (keys[i]) begin
      k = int'(keys[i]);
      if (!have_code) begin
        if (k <= 9) begin
          have_code = 1;
          code = k;
          digs.delete();
        end
      end else if (k <= 9) begin
        digs.push_back(k);
      end else if (k == 11) begin
        have_code = 0;
      end
    end
    foreach (digs[j]) val = val * 10 + digs[j];
    e_code = code;
    e_cnt  = val;
    if (code > 4) e_err = 1;
    else if (digs.size() == 0 || digs.size() > 2 || val == 0 || val > 15) e_err = 2;
`ifdef CHARGE_STOCK_SHADOW_EN
    else if (m_shadow[code] + val > 15) e_err = 3;
`endif
    else e_err = dp ? 4 : 0;
  endfunction

  task automatic run_request(input logic [3:0] keys[$], input bit dp, input int e_err,
                             input int e_code, input int e_cnt, input bit junk, input string tag);
    int  pulse_n = 0;
    int  strobe_cnt = 0;
    bit  both = 0;
    bit  unstable = 0;
    bit  busy1 = 0;
    bit  got_done = 0;
    bit  got_err = 0;
    int  errc = -1;
    bit  strobing;
    strobing = (e_err == 0 || e_err == 4);
    dp_in = dp;
    foreach (keys[i]) begin
      @(negedge clock);
      key_valid = 1'b1;
      key_value = keys[i];
    end
    for (int n = 1; n <= 20 && pulse_n == 0; n++) begin
      @(negedge clock);
      if (junk) begin
        key_valid = 1'b1;
        key_value = 4'($urandom_range(0, 15));
      end else begin
        key_valid = 1'b0;
      end
      if (n == 1) busy1 = busy;
      if (charge_strobe) begin
        strobe_cnt++;
        if (int'(productCode) != e_code || int'(productCount) != e_cnt) unstable = 1;
      end
      if (done && error) both = 1;
      if (done || error) begin
        pulse_n  = n;
        got_done = done;
        got_err  = error;
        errc     = int'(err_code);
        if (strobing && (int'(productCode) != e_code || int'(productCount) != e_cnt)) unstable = 1;
      end
    end
    key_valid = 1'b0;
    chk({tag, " busy"}, int'(busy1), 1);
    chk({tag, " latency"}, pulse_n, strobing ? 8 : 2);
    chk({tag, " done"}, int'(got_done), (e_err == 0) ? 1 : 0);
    chk({tag, " error"}, int'(got_err), (e_err != 0) ? 1 : 0);
    chk({tag, " err_code"}, errc, e_err);
    chk({tag, " strobe cycles"}, strobe_cnt, strobing ? 4 : 0);
    if (strobing) chk({tag, " product stable"}, int'(unstable), 0);
    chk({tag, " done&error"}, int'(both), 0);
    @(negedge clock);
    chk({tag, " pulse width"}, int'(done | error), 0);
    chk({tag, " idle after"}, int'(busy), 0);
    chk({tag, " err_code held"}, int'(err_code), e_err);
`ifdef CHARGE_STOCK_SHADOW_EN
    if (e_err == 0) m_shadow[e_code] += e_cnt;
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] q[$];
    int e_err, e_code, e_cnt;
    int nd;
    logic [31:0] kw;

    tbl[0]  = '{4'd3, 32'h0000027A, 1'b0, 3'd0, 3'd2, 4'd7};
    tbl[1]  = '{4'd3, 32'h0000063A, 1'b0, 3'd1, 3'd0, 4'd0};
    tbl[2]  = '{4'd4, 32'h0000116A, 1'b0, 3'd2, 3'd0, 4'd0};
    tbl[3]  = '{4'd5, 32'h0001001A, 1'b0, 3'd2, 3'd0, 4'd0};
    tbl[4]  = '{4'd2, 32'h0000001A, 1'b0, 3'd2, 3'd0, 4'd0};
    tbl[5]  = '{4'd3, 32'h0000039A, 1'b0, 3'd0, 3'd3, 4'd9};
`ifdef CHARGE_STOCK_SHADOW_EN
    tbl[6]  = '{4'd3, 32'h0000037A, 1'b0, 3'd3, 3'd0, 4'd0};
`else
    tbl[6]  = '{4'd3, 32'h0000037A, 1'b0, 3'd0, 3'd3, 4'd7};
`endif
    tbl[7]  = '{4'd3, 32'h0000045A, 1'b1, 3'd4, 3'd4, 4'd5};
    tbl[8]  = '{4'd4, 32'h0000415A, 1'b0, 3'd0, 3'd4, 4'd15};
    tbl[9]  = '{4'd3, 32'h0000030A, 1'b0, 3'd2, 3'd0, 4'd0};
    tbl[10] = '{4'd3, 32'h0000051A, 1'b0, 3'd1, 3'd0, 4'd0};
    tbl[11] = '{4'd4, 32'h0000115A, 1'b0, 3'd0, 3'd1, 4'd15};
`ifdef CHARGE_STOCK_SHADOW_EN
    tbl[12] = '{4'd3, 32'h0000011A, 1'b0, 3'd3, 3'd0, 4'd0};
`else
    tbl[12] = '{4'd3, 32'h0000011A, 1'b0, 3'd0, 3'd1, 4'd1};
`endif
    tbl[13] = '{4'd7, 32'h0AB2C01A, 1'b0, 3'd0, 3'd2, 4'd1};

`ifdef CHARGE_STOCK_SHADOW_EN
    for (int i = 0; i < 5; i++) m_shadow[i] = 0;
`endif

    reset = 1'b1;
    key_valid = 1'b0;
    key_value = 4'd0;
    dp_in = 1'b0;
    #12;
    chk("reset outputs", all_outputs(), 0);
    @(negedge clock);
    reset = 1'b0;

    // Directed table
    for (int t = 0; t < 14; t++) begin
      q.delete();
      kw = tbl[t].keys;
      for (int i = 0; i < int'(tbl[t].nkeys); i++) begin
        q.push_back(kw[4*(int'(tbl[t].nkeys)-1-i) +: 4]);
      end
      run_request(q, tbl[t].dp, int'(tbl[t].exp_err), int'(tbl[t].exp_code),
                  int'(tbl[t].exp_cnt), t[0], $sformatf("tbl%0d", t));
    end

    // Cancel: leaves err_code from the previous failure, no pulse, accumulators cleared
    q = '{4'h6, 4'h3, 4'hA};
    run_request(q, 1'b0, 1, 0, 0, 1'b0, "pre_cancel");
    q = '{4'h0, 4'h5, 4'hB};
    foreach (q[i]) begin
      @(negedge clock);
      key_valid = 1'b1;
      key_value = q[i];
    end
    begin
      bit activity = 0;
      for (int n = 0; n < 10; n++) begin
        @(negedge clock);
        key_valid = 1'b0;
        if (done || error || charge_strobe || busy) activity = 1;
      end
      chk("cancel no activity", int'(activity), 0);
      chk("cancel err_code kept", int'(err_code), 1);
    end
    q = '{4'h0, 4'h3, 4'hA};
    run_request(q, 1'b0, 0, 0, 3, 1'b0, "post_cancel");

    // Reset during ISSUE
    q = '{4'h2, 4'h7, 4'hA};
    dp_in = 1'b0;
    foreach (q[i]) begin
      @(negedge clock);
      key_valid = 1'b1;
      key_value = q[i];
    end
    @(negedge clock);
    key_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("strobe before reset", int'(charge_strobe), 1);
    #2 reset = 1'b1;
    #1;
    chk("strobe async drop", int'(charge_strobe), 0);
    chk("outputs under reset", all_outputs(), 0);
    @(negedge clock);
    reset = 1'b0;
`ifdef CHARGE_STOCK_SHADOW_EN
    for (int i = 0; i < 5; i++) m_shadow[i] = 0;
`endif
    begin
      bit activity = 0;
      for (int n = 0; n < 10; n++) begin
        @(negedge clock);
        if (done || error || charge_strobe || busy) activity = 1;
      end
      chk("no pulse after reset", int'(activity), 0);
    end
    q = '{4'h2, 4'h1, 4'h5, 4'hA};
    run_request(q, 1'b0, 0, 2, 15, 1'b0, "post_reset");

    // Randomized requests against the model
    for (int r = 0; r < 40; r++) begin
      bit dp;
      q.delete();
      if ($urandom_range(0, 3) == 0) q.push_back(4'($urandom_range(10, 15)));
      q.push_back(($urandom_range(0, 3) == 0) ? 4'($urandom_range(5, 9)) : 4'($urandom_range(0, 4)));
      if ($urandom_range(0, 5) == 0) begin
        q.push_back(4'($urandom_range(0, 9)));
        q.push_back(4'hB);
        q.push_back(4'($urandom_range(0, 4)));
      end
      case ($urandom_range(0, 9))
        0:       nd = 0;
        1:       nd = 3;
        2, 3, 4: nd = 1;
        default: nd = 2;
      endcase
      for (int d = 0; d < nd; d++) begin
        if (d == 0 && nd == 2) q.push_back(4'($urandom_range(0, 1)));
        else q.push_back(4'($urandom_range(0, 9)));
        if ($urandom_range(0, 7) == 0) q.push_back(4'($urandom_range(12, 15)));
      end
      q.push_back(4'hA);
      dp = ($urandom_range(0, 3) == 0);
      model(q, dp, e_err, e_code, e_cnt);
      run_request(q, dp, e_err, e_code, e_cnt, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
